// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, the zero-register constant and the writeback entry layout
package cpu_pkg;

    localparam int BIT_SIZE   = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [BIT_SIZE-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_bypass_match.sv
// wbq_bypass_match: youngest-wins match of one read address against pending writes
module wbq_bypass_match
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int bit_size = BIT_SIZE
) (
    input  logic [DEPTH:0]                 cand_valid,
    input  logic [DEPTH:0][REG_ADDR_W-1:0] cand_addr,
    input  logic [DEPTH:0][bit_size-1:0]   cand_data,
    input  logic [REG_ADDR_W-1:0]          read_reg,
    output logic                           hit,
    output logic [bit_size-1:0]            data
);

    // Candidates arrive oldest first, so the last match in the scan is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (cand_valid[i] && cand_addr[i] == read_reg && read_reg != REG_ZERO) begin
                hit  = 1'b1;
                data = cand_data[i];
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: FIFO of register writebacks feeding the register file write port, with read bypass
module reg_writeback_queue
    import cpu_pkg::*;
#(
    parameter int bit_size = BIT_SIZE,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REG_ADDR_W-1:0]    in_reg,
    input  logic [bit_size-1:0]      in_data,
    input  logic                     wb_stall,
    output logic                     RegWrite,
    output logic [REG_ADDR_W-1:0]    Write_reg,
    output logic [bit_size-1:0]      Write_data,
    input  logic [REG_ADDR_W-1:0]    Read_reg1,
    input  logic [REG_ADDR_W-1:0]    Read_reg2,
    output logic                     byp_hit1,
    output logic [bit_size-1:0]      byp_data1,
    output logic                     byp_hit2,
    output logic [bit_size-1:0]      byp_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [REG_ADDR_W-1:0]          q_addr [DEPTH];
    logic [bit_size-1:0]            q_data [DEPTH];
    logic [PW-1:0]                  wr_ptr, rd_ptr;
    logic                           push, pop;
    logic [DEPTH:0]                 cand_valid;
    logic [DEPTH:0][REG_ADDR_W-1:0] cand_addr;
    logic [DEPTH:0][bit_size-1:0]   cand_data;

    // Ready depends only on occupancy; writes to $0 complete the handshake but never enter the queue.
    assign in_ready = count < CW'(DEPTH);
    assign push     = in_valid && in_ready && in_reg != REG_ZERO;
    assign pop      = count != '0 && !wb_stall;

    // Queue storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= in_reg;
            q_data[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks push minus pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Output stage: one-cycle write pulse carrying the head entry; address/data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite   <= 1'b0;
            Write_reg  <= '0;
            Write_data <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                Write_reg  <= q_addr[rd_ptr];
                Write_data <= q_data[rd_ptr];
            end
        end
    end

    // Bypass candidates in age order: the in-flight write, then queue entries from the head.
    always_comb begin
        cand_valid[0] = RegWrite;
        cand_addr[0]  = Write_reg;
        cand_data[0]  = Write_data;
        for (int i = 0; i < DEPTH; i++) begin
            cand_valid[i+1] = CW'(i) < count;
            cand_addr[i+1]  = q_addr[rd_ptr + PW'(i)];
            cand_data[i+1]  = q_data[rd_ptr + PW'(i)];
        end
    end

    wbq_bypass_match #(.DEPTH(DEPTH), .bit_size(bit_size)) u_byp1 (
        .cand_valid (cand_valid),
        .cand_addr  (cand_addr),
        .cand_data  (cand_data),
        .read_reg   (Read_reg1),
        .hit        (byp_hit1),
        .data       (byp_data1)
    );

    wbq_bypass_match #(.DEPTH(DEPTH), .bit_size(bit_size)) u_byp2 (
        .cand_valid (cand_valid),
        .cand_addr  (cand_addr),
        .cand_data  (cand_data),
        .read_reg   (Read_reg2),
        .hit        (byp_hit2),
        .data       (byp_data2)
    );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed vector table plus reset, fill and random-order sequences
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        wb_stall = 1'b0;
    logic [4:0]  in_reg = '0;
    logic [31:0] in_data = '0;
    logic [4:0]  Read_reg1 = '0;
    logic [4:0]  Read_reg2 = '0;
    logic        in_ready, RegWrite, byp_hit1, byp_hit2;
    logic [4:0]  Write_reg;
    logic [31:0] Write_data, byp_data1, byp_data2;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    logic [36:0] obs[$];
    logic [36:0] expq[$];
    logic [36:0] mq[$];

    typedef struct {
        logic        iv;
        logic [4:0]  ir;
        logic [31:0] id;
        logic        st;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [107:0] exp;
    } vec_t;

    vec_t tv[$];

    reg_writeback_queue #(.bit_size(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .wb_stall   (wb_stall),
        .RegWrite   (RegWrite),
        .Write_reg  (Write_reg),
        .Write_data (Write_data),
        .Read_reg1  (Read_reg1),
        .Read_reg2  (Read_reg2),
        .byp_hit1   (byp_hit1),
        .byp_data1  (byp_data1),
        .byp_hit2   (byp_hit2),
        .byp_data2  (byp_data2),
        .count      (count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst && RegWrite) obs.push_back({Write_reg, Write_data});

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [107:0] o(input logic rdy, input logic rw, input logic [4:0] wr,
                                        input logic [31:0] wd, input logic [2:0] c,
                                        input logic h1, input logic [31:0] d1,
                                        input logic h2, input logic [31:0] d2);
        return {rdy, rw, wr, wd, c, h1, d1, h2, d2};
    endfunction

    task automatic add(input logic iv, input logic [4:0] ir, input logic [31:0] id, input logic st,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [107:0] exp);
        tv.push_back(vec_t'{iv, ir, id, st, r1, r2, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [36:0] fe[5];
        int   pushes;
        int   mcnt;
        bit   v, st, acc, held;
        logic [4:0]  r;
        logic [31:0] d;

        add(0, 0, 32'h0,        0, 0, 0, o(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0));
        add(1, 5, 32'hDEADBEEF, 0, 5, 0, o(1, 0, 0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 32'h0));
        add(0, 0, 32'h0,        0, 5, 0, o(1, 1, 5, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 32'h0));
        add(0, 0, 32'h0,        0, 5, 0, o(1, 0, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0));
        add(1, 0, 32'h1234,     0, 0, 0, o(1, 0, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0));
        add(0, 0, 32'h0,        0, 0, 0, o(1, 0, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0));
        add(1, 7, 32'h11,       1, 7, 8, o(1, 0, 5, 32'hDEADBEEF, 1, 1, 32'h11,       0, 32'h0));
        add(1, 7, 32'h22,       1, 7, 8, o(1, 0, 5, 32'hDEADBEEF, 2, 1, 32'h22,       0, 32'h0));
        add(1, 8, 32'h33,       1, 7, 8, o(1, 0, 5, 32'hDEADBEEF, 3, 1, 32'h22,       1, 32'h33));
        add(0, 0, 32'h0,        0, 7, 8, o(1, 1, 7, 32'h11,       2, 1, 32'h22,       1, 32'h33));
        add(1, 7, 32'h44,       0, 7, 8, o(1, 1, 7, 32'h22,       2, 1, 32'h44,       1, 32'h33));
        add(0, 0, 32'h0,        0, 7, 8, o(1, 1, 8, 32'h33,       1, 1, 32'h44,       1, 32'h33));
        add(0, 0, 32'h0,        0, 7, 8, o(1, 1, 7, 32'h44,       0, 1, 32'h44,       0, 32'h0));
        add(0, 0, 32'h0,        0, 7, 8, o(1, 0, 7, 32'h44,       0, 0, 32'h0,        0, 32'h0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_regwrite", RegWrite, 0);
        @(negedge clk);
        rst = 1'b1;

        obs.delete();
        for (int i = 0; i < tv.size(); i++) begin
            in_valid = tv[i].iv; in_reg = tv[i].ir; in_data = tv[i].id;
            wb_stall = tv[i].st; Read_reg1 = tv[i].r1; Read_reg2 = tv[i].r2;
            step();
            chk($sformatf("vec%0d", i),
                {in_ready, RegWrite, Write_reg, Write_data, count, byp_hit1, byp_data1, byp_hit2, byp_data2},
                tv[i].exp);
        end
        chk("table_write_total", obs.size(), 5);

        obs.delete();
        in_valid = 1'b0; Read_reg1 = '0; Read_reg2 = '0;
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_reg = 5'(i); in_data = 32'hA0 + 32'(i);
            fe[i-1] = {5'(i), 32'hA0 + 32'(i)};
            step();
        end
        fe[4] = {5'd9, 32'h99};
        chk("fill_count", count, 4);
        chk("fill_ready", in_ready, 0);
        in_reg = 5'd9; in_data = 32'h99;
        repeat (2) step();
        chk("fill_hold_count", count, 4);
        chk("fill_hold_rw", RegWrite, 0);
        wb_stall = 1'b0;
        step();
        chk("fill_pop1_count", count, 3);
        chk("fill_pop1_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("fill_pop2_count", count, 3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("fill_obs_n", obs.size(), 5);
        for (int i = 0; i < 5; i++) if (i < obs.size()) chk($sformatf("fill_order%0d", i), obs[i], fe[i]);
        chk("fill_ready_back", in_ready, 1);

        wb_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_reg = 5'(10 + i); in_data = 32'(i);
            step();
        end
        in_valid = 1'b0; wb_stall = 1'b0;
        step();
        chk("rst_pre_rw", RegWrite, 1);
        chk("rst_pre_count", count, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_count", count, 0);
        chk("rst_async_rw", RegWrite, 0);
        chk("rst_async_wreg", Write_reg, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        obs.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_no_stale", obs.size(), 0);
        chk("rst_post_count", count, 0);
        chk("rst_post_ready", in_ready, 1);

        obs.delete(); expq.delete(); mq.delete();
        pushes = 0; mcnt = 0; v = 0; held = 0; r = '0; d = '0;
        for (int cyc = 0; cyc < 300 && pushes < 20; cyc++) begin
            if (!held) begin
                v = ($urandom_range(0, 1) == 1);
                r = 5'($urandom_range(0, 7));
                d = $urandom;
            end
            st = ($urandom_range(0, 2) == 0);
            in_valid = v; in_reg = r; in_data = d; wb_stall = st;
            #1;
            chk("rnd_ready", in_ready, mcnt < DEPTH);
            acc = v && (mcnt < DEPTH);
            if (mcnt > 0 && !st) expq.push_back(mq.pop_front());
            if (acc && r != 5'd0) mq.push_back({r, d});
            if (acc) pushes++;
            held = v && !acc;
            mcnt = mq.size();
            step();
            chk("rnd_count", count, mcnt);
        end
        chk("rnd_pushes_done", pushes >= 20, 1);
        in_valid = 1'b0; wb_stall = 1'b0;
        repeat (6) @(posedge clk);
        while (mq.size() > 0) expq.push_back(mq.pop_front());
        @(negedge clk);
        chk("rnd_drain_count", count, 0);
        chk("rnd_obs_n", obs.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) if (i < obs.size()) chk($sformatf("rnd_order%0d", i), obs[i], expq[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
